// File: rtl/score_row_streamer.sv
// Captures a 4x4 score matrix scaled by 2^-SHIFT and streams it to softmax one row at a time.
// Define SCORE_ROUND_EN to round half-up when scaling; the default build truncates toward minus infinity.
module score_row_streamer #(
    parameter int width = 8,
    parameter int SHIFT = 1
) (
    input  logic                      clk,
    input  logic                      _reset,
    input  logic                      load,
    input  logic signed [2*width-1:0] in_00,
    input  logic signed [2*width-1:0] in_01,
    input  logic signed [2*width-1:0] in_02,
    input  logic signed [2*width-1:0] in_03,
    input  logic signed [2*width-1:0] in_10,
    input  logic signed [2*width-1:0] in_11,
    input  logic signed [2*width-1:0] in_12,
    input  logic signed [2*width-1:0] in_13,
    input  logic signed [2*width-1:0] in_20,
    input  logic signed [2*width-1:0] in_21,
    input  logic signed [2*width-1:0] in_22,
    input  logic signed [2*width-1:0] in_23,
    input  logic signed [2*width-1:0] in_30,
    input  logic signed [2*width-1:0] in_31,
    input  logic signed [2*width-1:0] in_32,
    input  logic signed [2*width-1:0] in_33,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [2*width-1:0] out_c0,
    output logic signed [2*width-1:0] out_c1,
    output logic signed [2*width-1:0] out_c2,
    output logic signed [2*width-1:0] out_c3,
    output logic signed [2*width-1:0] out_row_max,
    output logic [1:0]                out_row_idx,
    output logic                      done
);

    // state  | meaning
    // IDLE   | no frame held; outputs forced to zero; load captures a frame
    // STREAM | presenting row row_q; advances on out_ready, exits after row 3
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    localparam int EW = 2 * width;

`ifdef SCORE_ROUND_EN
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [EW:0] RND = (SHIFT > 0) ? ((EW + 1)'(1) << RND_POS) : '0;
`endif

    logic [0:0]             state_q, state_d;
    logic [1:0]             row_q, row_d;
    logic                   done_q, done_d;
    logic                   capture;
    logic                   streaming;
    logic signed [EW-1:0]   in_arr [16];
    logic signed [EW-1:0]   scaled [16];
    logic signed [EW-1:0]   rmax   [4];
    logic signed [EW-1:0]   buf_q  [16];
    logic signed [EW-1:0]   rmax_q [4];

    // One extra bit of headroom keeps the rounding add from overflowing before the shift.
    function automatic logic signed [EW-1:0] scale(input logic signed [EW-1:0] x);
        logic signed [EW:0] ext;
        ext = (EW + 1)'(x);
`ifdef SCORE_ROUND_EN
        ext = ext + RND;
`endif
        ext = ext >>> SHIFT;
        return EW'(ext);
    endfunction

    function automatic logic signed [EW-1:0] max4(
        input logic signed [EW-1:0] a,
        input logic signed [EW-1:0] b,
        input logic signed [EW-1:0] c,
        input logic signed [EW-1:0] d
    );
        logic signed [EW-1:0] ab;
        logic signed [EW-1:0] cd;
        ab = (a > b) ? a : b;
        cd = (c > d) ? c : d;
        return (ab > cd) ? ab : cd;
    endfunction

    assign in_arr[0]  = in_00;
    assign in_arr[1]  = in_01;
    assign in_arr[2]  = in_02;
    assign in_arr[3]  = in_03;
    assign in_arr[4]  = in_10;
    assign in_arr[5]  = in_11;
    assign in_arr[6]  = in_12;
    assign in_arr[7]  = in_13;
    assign in_arr[8]  = in_20;
    assign in_arr[9]  = in_21;
    assign in_arr[10] = in_22;
    assign in_arr[11] = in_23;
    assign in_arr[12] = in_30;
    assign in_arr[13] = in_31;
    assign in_arr[14] = in_32;
    assign in_arr[15] = in_33;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            scaled[i] = scale(in_arr[i]);
        end
        for (int r = 0; r < 4; r++) begin
            rmax[r] = max4(scaled[4*r], scaled[4*r+1], scaled[4*r+2], scaled[4*r+3]);
        end
    end

    assign capture = (state_q == IDLE) && load;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = STREAM;
                    row_d   = 2'd0;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (row_q == 2'd3) begin
                        state_d = IDLE;
                        row_d   = 2'd0;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                row_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q <= IDLE;
            row_q   <= 2'd0;
            done_q  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= '0;
            end
            for (int r = 0; r < 4; r++) begin
                rmax_q[r] <= '0;
            end
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            done_q  <= done_d;
            if (capture) begin
                for (int i = 0; i < 16; i++) begin
                    buf_q[i] <= scaled[i];
                end
                for (int r = 0; r < 4; r++) begin
                    rmax_q[r] <= rmax[r];
                end
            end
        end
    end

    // The buffer keeps the last frame after streaming, so outputs are gated by state.
    assign streaming   = (state_q == STREAM);
    assign busy        = streaming;
    assign out_valid   = streaming;
    assign done        = done_q;
    assign out_row_idx = streaming ? row_q : 2'd0;
    assign out_c0      = streaming ? buf_q[{row_q, 2'd0}] : '0;
    assign out_c1      = streaming ? buf_q[{row_q, 2'd1}] : '0;
    assign out_c2      = streaming ? buf_q[{row_q, 2'd2}] : '0;
    assign out_c3      = streaming ? buf_q[{row_q, 2'd3}] : '0;
    assign out_row_max = streaming ? rmax_q[row_q] : '0;

endmodule

// File: tb/tb_score_row_streamer.sv
// Self-checking bench for score_row_streamer: table vectors, directed corner sequences, random traffic vs a reference model.
module tb_score_row_streamer;
    localparam int W  = 8;
    localparam int SH = 1;
    localparam int EW = 2 * W;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic load = 1'b0;
    logic ready = 1'b0;
    logic signed [EW-1:0] din [16];
    logic busy, out_valid, done;
    logic signed [EW-1:0] out_c0, out_c1, out_c2, out_c3, out_row_max;
    logic [1:0] out_row_idx;

    int n_chk = 0;
    int n_fail = 0;

    // reference model state
    bit m_act;
    int m_row;
    bit m_done;
    int m_buf [16];
    int m_max [4];

    typedef struct {
        int e  [4];
        int q  [4];
        int mx;
    } vec_t;
    vec_t tbl [4];

    score_row_streamer #(.width(W), .SHIFT(SH)) dut (
        .clk(clk), ._reset(rst_n), .load(load),
        .in_00(din[0]),  .in_01(din[1]),  .in_02(din[2]),  .in_03(din[3]),
        .in_10(din[4]),  .in_11(din[5]),  .in_12(din[6]),  .in_13(din[7]),
        .in_20(din[8]),  .in_21(din[9]),  .in_22(din[10]), .in_23(din[11]),
        .in_30(din[12]), .in_31(din[13]), .in_32(din[14]), .in_33(din[15]),
        .busy(busy), .out_valid(out_valid), .out_ready(ready),
        .out_c0(out_c0), .out_c1(out_c1), .out_c2(out_c2), .out_c3(out_c3),
        .out_row_max(out_row_max), .out_row_idx(out_row_idx), .done(done)
    );

    always #5 clk = ~clk;

    // Division-based scaling, independent of any shift implementation.
    function automatic int mscale(input int x);
        int d;
        int v;
        int q;
        d = 1 << SH;
        v = x;
`ifdef SCORE_ROUND_EN
        if (SH > 0) v = v + d / 2;
`endif
        q = v / d;
        if ((v % d != 0) && (v < 0)) q = q - 1;
        return q;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act = 1'b0;
        m_row = 0;
        m_done = 1'b0;
        for (int i = 0; i < 16; i++) m_buf[i] = 0;
        for (int r = 0; r < 4; r++) m_max[r] = 0;
    endtask

    task automatic check_outputs(input string tag);
        int base;
        base = m_row * 4;
        chk({tag, ".busy"},  int'(busy), int'(m_act));
        chk({tag, ".valid"}, int'(out_valid), int'(m_act));
        chk({tag, ".done"},  int'(done), int'(m_done));
        chk({tag, ".idx"},   int'(out_row_idx), m_act ? m_row : 0);
        chk({tag, ".c0"},    int'(out_c0), m_act ? m_buf[base]   : 0);
        chk({tag, ".c1"},    int'(out_c1), m_act ? m_buf[base+1] : 0);
        chk({tag, ".c2"},    int'(out_c2), m_act ? m_buf[base+2] : 0);
        chk({tag, ".c3"},    int'(out_c3), m_act ? m_buf[base+3] : 0);
        chk({tag, ".max"},   int'(out_row_max), m_act ? m_max[m_row] : 0);
    endtask

    // Apply one clock of inputs, advance the model by the same rules, compare after the edge.
    task automatic cycle(input bit ld, input bit rdy, input string tag);
        bit nd;
        int mx;
        load = ld;
        ready = rdy;
        nd = 1'b0;
        if (!m_act) begin
            if (ld) begin
                for (int i = 0; i < 16; i++) m_buf[i] = mscale(int'(din[i]));
                for (int r = 0; r < 4; r++) begin
                    mx = m_buf[4*r];
                    for (int c = 1; c < 4; c++) if (m_buf[4*r+c] > mx) mx = m_buf[4*r+c];
                    m_max[r] = mx;
                end
                m_act = 1'b1;
                m_row = 0;
            end
        end else if (rdy) begin
            if (m_row == 3) begin
                m_act = 1'b0;
                m_row = 0;
                nd = 1'b1;
            end else begin
                m_row = m_row + 1;
            end
        end
        m_done = nd;
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic rand_din();
        for (int i = 0; i < 16; i++) din[i] = EW'($urandom);
    endtask

    initial begin
        tbl[0].e = '{100, -4, 7, 20};
        tbl[1].e = '{-3, 3, -1, 1};
        tbl[2].e = '{32767, -32768, 0, -1};
        tbl[3].e = '{-10, -20, -6, -7};
`ifdef SCORE_ROUND_EN
        tbl[0].q = '{50, -2, 4, 10};          tbl[0].mx = 50;
        tbl[1].q = '{-1, 2, 0, 1};            tbl[1].mx = 2;
        tbl[2].q = '{16384, -16384, 0, 0};    tbl[2].mx = 16384;
        tbl[3].q = '{-5, -10, -3, -3};        tbl[3].mx = -3;
`else
        tbl[0].q = '{50, -2, 3, 10};          tbl[0].mx = 50;
        tbl[1].q = '{-2, 1, -1, 0};           tbl[1].mx = 1;
        tbl[2].q = '{16383, -16384, 0, -1};   tbl[2].mx = 16383;
        tbl[3].q = '{-5, -10, -3, -4};        tbl[3].mx = -3;
`endif
        for (int i = 0; i < 16; i++) din[i] = '0;
        model_reset();

        #1 rst_n = 1'b0;
        #11;
        check_outputs("reset");
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("post_reset");

        // table-driven frame with continuous ready
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) din[4*r+c] = EW'(tbl[r].e[c]);
        cycle(1'b1, 1'b1, "tbl_load");
        for (int r = 0; r < 4; r++) begin
            chk("tbl.idx", int'(out_row_idx), r);
            chk("tbl.c0", int'(out_c0), tbl[r].q[0]);
            chk("tbl.c1", int'(out_c1), tbl[r].q[1]);
            chk("tbl.c2", int'(out_c2), tbl[r].q[2]);
            chk("tbl.c3", int'(out_c3), tbl[r].q[3]);
            chk("tbl.max", int'(out_row_max), tbl[r].mx);
            cycle(1'b0, 1'b1, "tbl_row");
        end
        chk("tbl.done", int'(done), 1);
        cycle(1'b0, 1'b1, "tbl_after_done");
        chk("tbl.done_pulse", int'(done), 0);

        // backpressure on row 1
        rand_din();
        cycle(1'b1, 1'b1, "bp_load");
        cycle(1'b0, 1'b1, "bp_row1");
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b0, "bp_hold");
            chk("bp.idx_hold", int'(out_row_idx), 1);
        end
        cycle(1'b0, 1'b1, "bp_release");
        chk("bp.idx_next", int'(out_row_idx), 2);
        cycle(1'b0, 1'b1, "bp_row3");
        cycle(1'b0, 1'b1, "bp_done");

        // load during stream is ignored; load in done cycle starts next frame at once
        rand_din();
        cycle(1'b1, 1'b1, "ign_load");
        for (int k = 0; k < 3; k++) begin
            rand_din();
            cycle(1'b1, 1'b1, "ign_stream");
        end
        rand_din();
        cycle(1'b0, 1'b1, "ign_last");
        chk("b2b.done", int'(done), 1);
        rand_din();
        cycle(1'b1, 1'b0, "b2b_load");
        chk("b2b.valid", int'(out_valid), 1);
        chk("b2b.idx", int'(out_row_idx), 0);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, "b2b_stream");

        // reset mid-stream at row 2
        rand_din();
        cycle(1'b1, 1'b1, "rst_load");
        cycle(1'b0, 1'b1, "rst_row1");
        cycle(1'b0, 1'b1, "rst_row2");
        chk("rst.idx_before", int'(out_row_idx), 2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_async");
        @(posedge clk);
        #3 rst_n = 1'b1;
        cycle(1'b0, 1'b1, "rst_idle");
        chk("rst.no_done", int'(done), 0);
        rand_din();
        cycle(1'b1, 1'b1, "rst_reload");
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, "rst_stream");

        // random traffic
        for (int k = 0; k < 400; k++) begin
            rand_din();
            if ((k % 37) == 5) din[$urandom_range(0, 15)] = 16'sh8000;
            cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
